lb_hub: RTL and testbench
=========================

Name: lb_hub

Overview:
Parametrised LocalBus hub and register core for the SUMP2/GPIO designs. It replaces hard-wired per-core address decode and readback muxing. One master-side LocalBus port fans out to N_CH child channels, each owning one address window. Window 0 holds built-in ID/version/timestamp/scratch/error registers. Child reads are tracked by a state machine with a timeout, so a dead or unmapped slave returns a fixed pattern instead of hanging the host.

Parameters:
N_CH, 4, number of child channels (1..15)
WIN_BITS, 5, log2 of window size in bytes; channel index field is lb_addr[WIN_BITS+CH_BITS-1:WIN_BITS], CH_BITS=clog2(N_CH+1)
TIMEOUT, 16, maximum WAIT cycles for a child ch_rd_rdy (2..255)
ID_VAL, 32'h11223344, value of register 0x00
VER_VAL, 32'h00000200, value of register 0x04
TO_DATA, 32'hDEADBEEF, read data returned on timeout

Ports:
clk_lb  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
lb_wr  in  1  master write strobe, one cycle per access
lb_rd  in  1  master read strobe, one cycle per access
lb_addr  in  32  byte address
lb_wr_d  in  32  write data
lb_rd_d  out  32  read data, valid only while lb_rd_rdy=1, else 0
lb_rd_rdy  out  1  one-cycle read-data-valid pulse
time_stamp_d  in  32  build timestamp, readable at 0x08
ch_cs  out  N_CH  one-hot channel select, qualifies ch_wr/ch_rd
ch_wr  out  1  write strobe to selected channel
ch_rd  out  1  read strobe to selected channel
ch_addr  out  32  registered copy of lb_addr
ch_wr_d  out  32  registered copy of lb_wr_d
ch_rd_d  in  32*N_CH  channel i read data in bits [32i+31:32i]
ch_rd_rdy  in  N_CH  per-channel read-valid pulse

Behaviour:
- Reset values:
  - lb_rd_d=0, lb_rd_rdy=0, ch_cs=0, ch_wr=0, ch_rd=0, ch_addr=0, ch_wr_d=0.
  - scratch=0, to_cnt=0, state=IDLE.
- Input stage: lb_wr, lb_rd, lb_addr and lb_wr_d are flopped into p1 registers (cycle T -> T+1). Decode uses the p1 values only.
- Address decode: idx = p1 address channel field.
  - idx=0: local window.
  - 1..N_CH: channel idx-1.
  - >N_CH: unmapped.
  - Bits above the channel field are ignored.
- Local registers (offset = addr[WIN_BITS-1:0]):
  - 0x00 ID_VAL, read-only.
  - 0x04 VER_VAL, read-only.
  - 0x08 time_stamp_d, read-only.
  - 0x0C scratch, read/write.
  - 0x10 to_cnt, read-only in bits [15:0], upper bits 0. Any write to 0x10 clears it.
  - Other offsets read 0; writes to them are ignored.
- Writes:
  - Channel write strobed at T: ch_wr=1 and ch_cs one-hot at T+1, for one cycle.
  - Local write: the register is updated at the T+1 edge, so a read issued at T+1 sees the new value.
  - Writes are accepted in any state.
  - Unmapped writes are dropped.
- FSM states: IDLE, WAIT.
- IDLE, read strobed at T:
  - Local or unmapped read: lb_rd_rdy=1 at T+2 with the local value, or 0 for unmapped. State stays IDLE.
  - Channel read: ch_rd=1 and ch_cs at T+1 (one cycle). State moves to WAIT at T+2 with wait counter = 0 and the selected channel latched.
- WAIT:
  - Each cycle, sample ch_rd_rdy[sel].
  - If ch_rd_rdy[sel]=1: next cycle lb_rd_rdy=1, lb_rd_d=ch_rd_d[sel]; go to IDLE.
  - Else, if wait counter = TIMEOUT-1: next cycle lb_rd_rdy=1, lb_rd_d=TO_DATA; to_cnt increments (saturates at 16'hFFFF); go to IDLE.
  - Otherwise increment the wait counter.
  - Rdy on the final WAIT cycle wins over the timeout.
- Response latency:
  - Fastest channel response (ch_rd_rdy at T+2): lb_rd_rdy at T+3.
  - Timeout response: lb_rd_rdy at T+2+TIMEOUT.
- Ignored inputs:
  - ch_rd_rdy from non-selected channels, and any ch_rd_rdy in IDLE (including late ones after a timeout).
  - lb_rd strobed while in WAIT: no ch_rd, no response, FSM unaffected. The master issues one read at a time.
- Reset mid-WAIT: return to IDLE with no lb_rd_rdy, wait counter cleared, to_cnt cleared.
- lb_rd and lb_wr in the same cycle: the write is performed and the read is handled as above.

Test Plan:
- Read 0x00, 0x04, 0x0C after reset -> lb_rd_rdy at T+2 with 11223344, 00000200, 00000000; exactly one rdy pulse each.
- Write 0x0C=A5A5_0001, then read 0x0C -> A5A5_0001. Read 0x1C -> 0, with rdy.
- With N_CH=4, WIN_BITS=5, read 0x44 (channel 1): ch_rd=1, ch_cs=4'b0010, ch_addr=0x44 at T+1. The channel model returns 0x12345678 at T+4 -> lb_rd_rdy at T+5 with 0x12345678. Concurrent ch_rd_rdy[0] pulse is ignored.
- Channel 3 silent, TIMEOUT=16 -> lb_rd_rdy at T+18 with DEADBEEF. Read 0x10 -> 1. A late ch_rd_rdy[3] at T+20 -> no response. Write 0x10, then read 0x10 -> 0.
- Rdy exactly on the last WAIT cycle (T+17) -> data returned at T+18, to_cnt unchanged.
- Reset asserted at T+5 during WAIT -> no lb_rd_rdy, FSM in IDLE. Next local read 0x08 returns time_stamp_d at T'+2. Read of unmapped window 0xA0 -> 0 at T+2, no ch_rd.

Source files
------------

// File: rtl/lb_hub.sv
// lb_hub: LocalBus hub and register core.
// One master LocalBus port fans out to N_CH child address windows. Window 0
// holds the built-in ID/version/timestamp/scratch/timeout-count registers.
// Child reads are tracked by an IDLE/WAIT machine with a timeout, so a dead or
// unmapped slave returns a fixed pattern instead of stalling the host.
module lb_hub #(
    parameter int          N_CH     = 4,
    parameter int          WIN_BITS = 5,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ID_VAL   = 32'h11223344,
    parameter logic [31:0] VER_VAL  = 32'h00000200,
    parameter logic [31:0] TO_DATA  = 32'hDEADBEEF
) (
    input  logic                 clk_lb,
    input  logic                 reset,
    input  logic                 lb_wr,
    input  logic                 lb_rd,
    input  logic [31:0]          lb_addr,
    input  logic [31:0]          lb_wr_d,
    output logic [31:0]          lb_rd_d,
    output logic                 lb_rd_rdy,
    input  logic [31:0]          time_stamp_d,
    output logic [N_CH-1:0]      ch_cs,
    output logic                 ch_wr,
    output logic                 ch_rd,
    output logic [31:0]          ch_addr,
    output logic [31:0]          ch_wr_d,
    input  logic [32*N_CH-1:0]   ch_rd_d,
    input  logic [N_CH-1:0]      ch_rd_rdy
);

    // Channel field width: index 0 is the local window, 1..N_CH the children.
    localparam int CH_BITS = $clog2(N_CH + 1);

    // Local register offsets inside window 0.
    localparam logic [WIN_BITS-1:0] OFF_ID      = WIN_BITS'(8'h00);
    localparam logic [WIN_BITS-1:0] OFF_VER     = WIN_BITS'(8'h04);
    localparam logic [WIN_BITS-1:0] OFF_TS      = WIN_BITS'(8'h08);
    localparam logic [WIN_BITS-1:0] OFF_SCRATCH = WIN_BITS'(8'h0C);
    localparam logic [WIN_BITS-1:0] OFF_TO_CNT  = WIN_BITS'(8'h10);

    // Wait counter value on the final WAIT cycle before a timeout.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    // Input stage (p1) registers.
    logic                r_p1_wr;
    logic                r_p1_rd;
    logic [31:0]         r_p1_addr;
    logic [31:0]         r_p1_wr_d;

    // Read tracking and response registers.
    state_t              r_state;
    logic [7:0]          r_wait_cnt;
    logic [CH_BITS-1:0]  r_sel;
    logic [31:0]         r_rd_d;
    logic                r_rd_rdy;

    // Local registers.
    logic [31:0]         r_scratch;
    logic [15:0]         r_to_cnt;

    // Decode of the p1 access.
    logic [CH_BITS-1:0]  w_idx;
    logic [CH_BITS-1:0]  w_ch_num;
    logic [WIN_BITS-1:0] w_offset;
    logic                w_is_local;
    logic                w_is_chan;
    logic                w_rd_go;
    logic                w_ch_rd_go;
    logic                w_ch_wr_go;
    logic                w_local_wr;
    logic [N_CH-1:0]     w_cs;
    logic                w_sel_rdy;
    logic [31:0]         w_sel_data;
    logic [31:0]         w_local_rd_d;

    // Register the master strobes, address and data; a read strobed while a
    // child read is outstanding is dropped here so it never reaches decode.
    always_ff @(posedge clk_lb) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            r_p1_wr   <= 1'b0;
            r_p1_rd   <= 1'b0;
            r_p1_addr <= '0;
            r_p1_wr_d <= '0;
        end else begin
            r_p1_wr   <= lb_wr;
            r_p1_rd   <= lb_rd && (r_state == ST_IDLE);
            r_p1_addr <= lb_addr;
            r_p1_wr_d <= lb_wr_d;
        end
    end

    // Address decode: channel field picks local window, a child, or nothing.
    assign w_idx      = r_p1_addr[WIN_BITS+CH_BITS-1:WIN_BITS];
    assign w_offset   = r_p1_addr[WIN_BITS-1:0];
    assign w_is_local = (w_idx == '0);
    assign w_is_chan  = (w_idx != '0) && (w_idx <= CH_BITS'(N_CH));
    assign w_ch_num   = w_idx - CH_BITS'(1);

    // A read is only started from IDLE; the overlap case (a second read
    // captured just before WAIT is entered) is blocked here as well.
    assign w_rd_go    = r_p1_rd && (r_state == ST_IDLE);
    assign w_ch_rd_go = w_rd_go && w_is_chan;
    assign w_ch_wr_go = r_p1_wr && w_is_chan;
    assign w_local_wr = r_p1_wr && w_is_local;

    // One-hot channel select for a child access in the p1 cycle.
    always_comb begin
        // NOTE: defaults first so no path leaves a combinational output
        // unassigned, which would otherwise infer a latch.
        w_cs = '0;
        if (w_ch_rd_go || w_ch_wr_go) begin
            for (int i = 0; i < N_CH; i++) begin
                if (w_ch_num == CH_BITS'(i)) begin
                    w_cs[i] = 1'b1;
                end
            end
        end
    end

    assign ch_cs   = w_cs;
    assign ch_rd   = w_ch_rd_go;
    assign ch_wr   = w_ch_wr_go;
    assign ch_addr = r_p1_addr;
    assign ch_wr_d = r_p1_wr_d;

    // Pick ready and data of the channel latched for the outstanding read.
    always_comb begin
        w_sel_rdy  = 1'b0;
        w_sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (r_sel == CH_BITS'(i)) begin
                w_sel_rdy  = ch_rd_rdy[i];
                w_sel_data = ch_rd_d[32*i +: 32];
            end
        end
    end

    // Local window readback mux; unlisted offsets read as zero.
    always_comb begin
        w_local_rd_d = '0;
        case (w_offset)
            OFF_ID:      w_local_rd_d = ID_VAL;
            OFF_VER:     w_local_rd_d = VER_VAL;
            OFF_TS:      w_local_rd_d = time_stamp_d;
            OFF_SCRATCH: w_local_rd_d = r_scratch;
            OFF_TO_CNT:  w_local_rd_d = {16'h0000, r_to_cnt};
            default:     w_local_rd_d = '0;
        endcase
    end

    // Scratch register write; takes effect at the end of the p1 cycle.
    always_ff @(posedge clk_lb) begin
        if (reset) begin
            r_scratch <= '0;
        end else if (w_local_wr && (w_offset == OFF_SCRATCH)) begin
            r_scratch <= r_p1_wr_d;
        end
    end

    // Read FSM: immediate local/unmapped replies, child reads wait for the
    // selected ready or time out; also maintains the timeout counter.
    always_ff @(posedge clk_lb) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_sel      <= '0;
            r_rd_d     <= '0;
            r_rd_rdy   <= 1'b0;
            r_to_cnt   <= '0;
        end else begin
            r_rd_rdy <= 1'b0;
            r_rd_d   <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (w_rd_go) begin
                        if (w_is_chan) begin
                            r_state    <= ST_WAIT;
                            r_wait_cnt <= '0;
                            r_sel      <= w_ch_num;
                        end else begin
                            r_rd_rdy <= 1'b1;
                            r_rd_d   <= w_is_local ? w_local_rd_d : 32'h0;
                        end
                    end
                end

                ST_WAIT: begin
                    if (w_sel_rdy) begin
                        r_rd_rdy <= 1'b1;
                        r_rd_d   <= w_sel_data;
                        r_state  <= ST_IDLE;
                    end else if (r_wait_cnt == LAST_WAIT) begin
                        r_rd_rdy <= 1'b1;
                        r_rd_d   <= TO_DATA;
                        r_state  <= ST_IDLE;
                        if (r_to_cnt != 16'hFFFF) begin
                            r_to_cnt <= r_to_cnt + 16'd1;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            // A host write to the counter clears it, winning over a
            // simultaneous timeout increment.
            if (w_local_wr && (w_offset == OFF_TO_CNT)) begin
                r_to_cnt <= '0;
            end
        end
    end

    assign lb_rd_d   = r_rd_d;
    assign lb_rd_rdy = r_rd_rdy;

endmodule

// File: tb/tb_lb_hub.sv
// tb_lb_hub: directed and randomized transactions against a transaction-level
// model of the hub (register values, expected reply latency and data).
module tb_lb_hub;

    localparam int          N_CH     = 4;
    localparam int          WIN_BITS = 5;
    localparam int          TIMEOUT  = 16;
    localparam int          CH_BITS  = $clog2(N_CH + 1);
    localparam logic [31:0] ID_VAL   = 32'h11223344;
    localparam logic [31:0] VER_VAL  = 32'h00000200;
    localparam logic [31:0] TO_DATA  = 32'hDEADBEEF;
    localparam int          WINDOW   = TIMEOUT + 8;

    logic                clk_lb = 1'b0;
    logic                reset;
    logic                lb_wr;
    logic                lb_rd;
    logic [31:0]         lb_addr;
    logic [31:0]         lb_wr_d;
    logic [31:0]         lb_rd_d;
    logic                lb_rd_rdy;
    logic [31:0]         time_stamp_d;
    logic [N_CH-1:0]     ch_cs;
    logic                ch_wr;
    logic                ch_rd;
    logic [31:0]         ch_addr;
    logic [31:0]         ch_wr_d;
    logic [32*N_CH-1:0]  ch_rd_d;
    logic [N_CH-1:0]     ch_rd_rdy;

    always #5 clk_lb = ~clk_lb;

    lb_hub #(
        .N_CH     (N_CH),
        .WIN_BITS (WIN_BITS),
        .TIMEOUT  (TIMEOUT),
        .ID_VAL   (ID_VAL),
        .VER_VAL  (VER_VAL),
        .TO_DATA  (TO_DATA)
    ) dut (
        .clk_lb       (clk_lb),
        .reset        (reset),
        .lb_wr        (lb_wr),
        .lb_rd        (lb_rd),
        .lb_addr      (lb_addr),
        .lb_wr_d      (lb_wr_d),
        .lb_rd_d      (lb_rd_d),
        .lb_rd_rdy    (lb_rd_rdy),
        .time_stamp_d (time_stamp_d),
        .ch_cs        (ch_cs),
        .ch_wr        (ch_wr),
        .ch_rd        (ch_rd),
        .ch_addr      (ch_addr),
        .ch_wr_d      (ch_wr_d),
        .ch_rd_d      (ch_rd_d),
        .ch_rd_rdy    (ch_rd_rdy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    logic [31:0] m_scratch = '0;
    int          m_to_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_lb);
        #1;
    endtask

    // Channel field of an address: 0 local, 1..N_CH child, above that unmapped.
    function automatic int field_of(input logic [31:0] a);
        return int'((a >> WIN_BITS) & ((32'd1 << CH_BITS) - 1));
    endfunction

    function automatic logic [31:0] model_local(input logic [31:0] a);
        case (a & ((32'd1 << WIN_BITS) - 1))
            32'h00:  return ID_VAL;
            32'h04:  return VER_VAL;
            32'h08:  return time_stamp_d;
            32'h0C:  return m_scratch;
            32'h10:  return 32'(m_to_cnt);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [N_CH-1:0] exp_cs_of(input int f);
        logic [N_CH-1:0] cs = '0;
        if (f >= 1 && f <= N_CH) cs[f-1] = 1'b1;
        return cs;
    endfunction

    // Write transaction; the model takes the write at once, since a read
    // issued on the very next cycle must already see it.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input string tag);
        int f = field_of(a);
        bit is_ch = (f >= 1 && f <= N_CH);
        lb_wr   = 1'b1;
        lb_addr = a;
        lb_wr_d = d;
        step();
        lb_wr   = 1'b0;
        check({tag, ".ch_wr"}, 32'(ch_wr), 32'(is_ch));
        check({tag, ".ch_cs"}, 32'(ch_cs), 32'(exp_cs_of(f)));
        if (is_ch) check({tag, ".ch_wr_d"}, ch_wr_d, d);
        if (f == 0) begin
            if ((a & 32'h1F) == 32'h0C) m_scratch = d;
            if ((a & 32'h1F) == 32'h10) m_to_cnt = 0;
        end
    endtask

    // Read transaction. delay: child ready at T+2+delay (negative = silent).
    // late: extra ready pulse on the selected channel at T+late (0 = none).
    // noise: hold ready high on another channel. intr: strobe a second read
    // at T+intr (0 = none).
    task automatic do_read(input logic [31:0] a, input int delay, input int late,
                           input bit noise, input int intr, input string tag);
        int          f       = field_of(a);
        bit          is_ch   = (f >= 1 && f <= N_CH);
        bit          in_time = (delay >= 0 && delay < TIMEOUT);
        logic [31:0] ch_data = $urandom;
        int          exp_lat;
        logic [31:0] exp_d;
        int          got_lat = 0;
        logic [31:0] got_d   = '0;
        int          pulses  = 0;
        bit          leak    = 1'b0;
        bit          extra   = 1'b0;

        if (is_ch) begin
            exp_lat = in_time ? 3 + delay : 2 + TIMEOUT;
            exp_d   = in_time ? ch_data : TO_DATA;
        end else begin
            exp_lat = 2;
            exp_d   = (f == 0) ? model_local(a) : 32'h0;
        end

        lb_rd   = 1'b1;
        lb_addr = a;
        step();
        lb_rd   = 1'b0;
        check({tag, ".ch_rd"}, 32'(ch_rd), 32'(is_ch));
        check({tag, ".ch_cs"}, 32'(ch_cs), 32'(exp_cs_of(f)));
        if (is_ch) check({tag, ".ch_addr"}, ch_addr, a);

        for (int n = 1; n <= WINDOW; n++) begin
            if (lb_rd_rdy) begin
                pulses++;
                if (got_lat == 0) begin
                    got_lat = n;
                    got_d   = lb_rd_d;
                end
            end else if (lb_rd_d != 32'h0) begin
                leak = 1'b1;
            end
            if (n > 1 && ch_rd) extra = 1'b1;

            lb_rd     = (n == intr);
            lb_addr   = (n == intr) ? 32'h20 : $urandom;
            ch_rd_rdy = '0;
            if (is_ch && ((in_time && n == 2 + delay) || n == late)) ch_rd_rdy[f-1] = 1'b1;
            if (is_ch && noise && N_CH > 1) ch_rd_rdy[f % N_CH] = 1'b1;
            for (int c = 0; c < N_CH; c++) begin
                ch_rd_d[32*c +: 32] = (is_ch && c == f - 1) ? ch_data : 32'($urandom);
            end
            step();
        end
        lb_rd     = 1'b0;
        ch_rd_rdy = '0;

        if (is_ch && !in_time && m_to_cnt < 16'hFFFF) m_to_cnt++;

        check({tag, ".latency"}, 32'(got_lat), 32'(exp_lat));
        check({tag, ".data"}, got_d, exp_d);
        check({tag, ".pulses"}, 32'(pulses), 32'd1);
        check({tag, ".idle_data"}, 32'(leak), 32'd0);
        check({tag, ".no_extra_ch_rd"}, 32'(extra), 32'd0);
    endtask

    initial begin
        int pulses;

        reset        = 1'b1;
        lb_wr        = 1'b0;
        lb_rd        = 1'b0;
        lb_addr      = $urandom;
        lb_wr_d      = $urandom;
        time_stamp_d = $urandom;
        ch_rd_d      = '0;
        ch_rd_rdy    = '0;
        step();
        step();
        step();
        check("rst.lb_rd_d", lb_rd_d, 32'h0);
        check("rst.lb_rd_rdy", 32'(lb_rd_rdy), 32'h0);
        check("rst.ch_cs", 32'(ch_cs), 32'h0);
        check("rst.ch_wr", 32'(ch_wr), 32'h0);
        check("rst.ch_rd", 32'(ch_rd), 32'h0);
        check("rst.ch_addr", ch_addr, 32'h0);
        check("rst.ch_wr_d", ch_wr_d, 32'h0);
        reset = 1'b0;
        step();

        // Local registers after reset.
        do_read(32'h00, 0, 0, 1'b0, 0, "rd_id");
        do_read(32'h04, 0, 0, 1'b0, 0, "rd_ver");
        do_read(32'h0C, 0, 0, 1'b0, 0, "rd_scratch0");

        // Scratch write/readback and an unused offset.
        do_write(32'h0C, 32'hA5A5_0001, "wr_scratch");
        do_read(32'h0C, 0, 0, 1'b0, 0, "rd_scratch1");
        do_read(32'h1C, 0, 0, 1'b0, 0, "rd_hole");

        // Channel 1, ready at T+4, with ready held on another channel.
        do_read(32'h44, 2, 0, 1'b1, 0, "rd_ch1");

        // Channel 3 silent: timeout, counter, late ready ignored, clear.
        do_read(32'h80, -1, 20, 1'b0, 0, "rd_ch3_to");
        do_read(32'h10, 0, 0, 1'b0, 0, "rd_tocnt1");
        do_write(32'h10, 32'h0, "wr_tocnt");
        do_read(32'h10, 0, 0, 1'b0, 0, "rd_tocnt0");

        // Ready on the final WAIT cycle wins over the timeout.
        do_read(32'h80, TIMEOUT - 1, 0, 1'b0, 0, "rd_ch3_last");
        do_read(32'h10, 0, 0, 1'b0, 0, "rd_tocnt_same");

        // A read strobed during WAIT is ignored.
        do_read(32'h60, -1, 0, 1'b0, 5, "rd_ch2_intr");

        // Reset asserted at T+5 while waiting on channel 2.
        do_write(32'h0C, 32'h1357_9BDF, "wr_scratch2");
        lb_rd   = 1'b1;
        lb_addr = 32'h60;
        step();
        lb_rd = 1'b0;
        step();
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset  = 1'b0;
        pulses = 0;
        for (int n = 0; n < WINDOW; n++) begin
            if (lb_rd_rdy) pulses++;
            ch_rd_rdy = (n == 3) ? N_CH'(4'b0100) : '0;
            step();
        end
        ch_rd_rdy = '0;
        check("rst_wait.pulses", 32'(pulses), 32'h0);
        m_scratch = '0;
        m_to_cnt  = 0;
        do_read(32'h08, 0, 0, 1'b0, 0, "rd_ts");
        do_read(32'h10, 0, 0, 1'b0, 0, "rd_tocnt_rst");
        do_read(32'h0C, 0, 0, 1'b0, 0, "rd_scratch_rst");
        do_read(32'hA0, 0, 0, 1'b0, 0, "rd_unmapped");

        // Randomized traffic.
        for (int t = 0; t < 120; t++) begin
            int          kind  = $urandom_range(0, 5);
            logic [31:0] upper = $urandom & 32'hFFFF_FF00;
            logic [31:0] off   = 32'($urandom_range(0, 7) * 4);
            int          ch    = $urandom_range(1, N_CH);
            int          um    = $urandom_range(N_CH + 1, (1 << CH_BITS) - 1);
            int          dly   = $urandom_range(0, TIMEOUT + 2);
            int          intr;
            if (dly >= TIMEOUT) dly = -1;
            intr = ((dly < 0 || dly > 6) && $urandom_range(0, 3) == 0) ? 5 : 0;
            case (kind)
                0: do_write(upper | off, $urandom, "r_wr_local");
                1: do_read(upper | off, 0, 0, 1'b0, 0, "r_rd_local");
                2: do_read(upper | 32'(ch << WIN_BITS) | off, dly,
                           ($urandom_range(0, 1) == 1) ? WINDOW - 2 : 0,
                           1'($urandom_range(0, 1)), intr, "r_rd_ch");
                3: do_write(upper | 32'(ch << WIN_BITS) | off, $urandom, "r_wr_ch");
                4: begin
                    if ($urandom_range(0, 1) == 1)
                        do_read(upper | 32'(um << WIN_BITS) | off, 0, 0, 1'b0, 0, "r_rd_unmapped");
                    else
                        do_write(upper | 32'(um << WIN_BITS) | off, $urandom, "r_wr_unmapped");
                end
                default: do_read(upper | 32'h10, 0, 0, 1'b0, 0, "r_rd_tocnt");
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
